// File: rtl/lane_mux_nto_m_l1.sv
// rtl/lane_mux_nto_m_l1.sv - N_IN to N_OUT byte-lane muxer with frame phase, shadow bank and frame markers
// Optional feature macro: IDLE_INSERT_EN (invalid slots drive IDLE_BYTE instead of holding).
module lane_mux_nto_m_l1 #(
  parameter int                DATA_W    = 8,
  parameter int                N_IN      = 4,
  parameter int                N_OUT     = 2,
  parameter logic [DATA_W-1:0] IDLE_BYTE = DATA_W'(8'hBC)
) (
  input  logic                                            clk_2f,
  input  logic                                            reset,
  input  logic [N_IN*DATA_W-1:0]                          in_data,
  input  logic [N_IN-1:0]                                 in_valid,
  output logic                                            in_ready,
  output logic [N_OUT*DATA_W-1:0]                         out_data,
  output logic [N_OUT-1:0]                                out_valid,
  output logic [((N_IN/N_OUT) > 2 ? $clog2(N_IN/N_OUT) : 1)-1:0] out_phase,
  output logic                                            frame_start
);

  localparam int R  = N_IN / N_OUT;
  localparam int PW = (R > 2) ? $clog2(R) : 1;

  generate
    if (N_OUT < 1 || (N_IN % N_OUT) != 0 || R < 2 || (R & (R - 1)) != 0 ||
        $bits(IDLE_BYTE) != DATA_W) begin : g_bad_ratio
      $error("lane_mux_nto_m_l1: N_IN/N_OUT must be a power of two >= 2");
    end
  endgenerate

  logic [PW-1:0]            phase_q, phase_d;
  logic [N_IN*DATA_W-1:0]   shadow_data_q, shadow_data_d;
  logic [N_IN-1:0]          shadow_valid_q, shadow_valid_d;
  logic [N_OUT*DATA_W-1:0]  out_data_q, out_data_d;
  logic [N_OUT-1:0]         out_valid_q, out_valid_d;
  logic [PW-1:0]            out_phase_q, out_phase_d;
  logic                     frame_start_q, frame_start_d;
  logic                     capture;
  logic [DATA_W-1:0]        sel_data;
  logic                     sel_valid;
  int                       src;

  assign capture  = (phase_q == '0);
  assign in_ready = capture;

  // Phase wraps naturally because R is exactly 2**PW.
  always_comb begin
    phase_d        = phase_q + 1'b1;
    shadow_data_d  = capture ? in_data  : shadow_data_q;
    shadow_valid_d = capture ? in_valid : shadow_valid_q;
    out_phase_d    = phase_q;
    frame_start_d  = capture;
  end

  // Phase 0 bypasses the shadow so the first element leaves on the capture edge.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = '0;
    sel_data    = '0;
    sel_valid   = 1'b0;
    src         = 0;
    for (int j = 0; j < N_OUT; j++) begin
      src = j * R + int'(phase_q);
      if (capture) begin
        sel_data  = in_data[src*DATA_W +: DATA_W];
        sel_valid = in_valid[src];
      end else begin
        sel_data  = shadow_data_q[src*DATA_W +: DATA_W];
        sel_valid = shadow_valid_q[src];
      end
      out_valid_d[j] = sel_valid;
      if (sel_valid) begin
        out_data_d[j*DATA_W +: DATA_W] = sel_data;
      end
`ifdef IDLE_INSERT_EN
      else begin
        out_data_d[j*DATA_W +: DATA_W] = IDLE_BYTE;
      end
`endif
    end
  end

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      phase_q        <= '0;
      shadow_data_q  <= '0;
      shadow_valid_q <= '0;
      out_data_q     <= '0;
      out_valid_q    <= '0;
      out_phase_q    <= '0;
      frame_start_q  <= 1'b0;
    end else begin
      phase_q        <= phase_d;
      shadow_data_q  <= shadow_data_d;
      shadow_valid_q <= shadow_valid_d;
      out_data_q     <= out_data_d;
      out_valid_q    <= out_valid_d;
      out_phase_q    <= out_phase_d;
      frame_start_q  <= frame_start_d;
    end
  end

  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign out_phase   = out_phase_q;
  assign frame_start = frame_start_q;

endmodule
